// File: rtl/axi_lite_reg_slave.sv
// AXI4-Lite responder over a bank of NUM_REGS byte-writable 32-bit registers.
// AW and W are buffered independently; the bank is exported flat on regs_o.
module axi_lite_reg_slave #(
  parameter int unsigned NUM_REGS = 16
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic [31:0]              awaddr,
  input  logic [2:0]               awprot,
  input  logic                     awvalid,
  output logic                     awready,
  input  logic [31:0]              wdata,
  input  logic [3:0]               wstrb,
  input  logic                     wvalid,
  output logic                     wready,
  output logic [1:0]               bresp,
  output logic                     bvalid,
  input  logic                     bready,
  input  logic [31:0]              araddr,
  input  logic [2:0]               arprot,
  input  logic                     arvalid,
  output logic                     arready,
  output logic [31:0]              rdata,
  output logic [1:0]               rresp,
  output logic                     rvalid,
  input  logic                     rready,
  output logic [32*NUM_REGS-1:0]   regs_o
);

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespDecerr = 2'b11;

  logic                            init_q;
  logic                            aw_full_q, aw_full_d;
  logic [29:0]                     aw_idx_q, aw_idx_d;
  logic                            w_full_q, w_full_d;
  logic [31:0]                     wdata_q, wdata_d;
  logic [3:0]                      wstrb_q, wstrb_d;
  logic                            bvalid_q, bvalid_d;
  logic [1:0]                      bresp_q, bresp_d;
  logic                            rvalid_q, rvalid_d;
  logic [31:0]                     rdata_q, rdata_d;
  logic [1:0]                      rresp_q, rresp_d;
  logic [NUM_REGS-1:0][31:0]       regs_q, regs_d;

  logic aw_hs, w_hs, ar_hs, commit;
  logic [29:0] ar_idx;

  // Address LSBs and protection bits carry no meaning for this bank.
  logic unused_inputs;
  assign unused_inputs = ^{awprot, arprot, awaddr[1:0], araddr[1:0]};

  assign awready = init_q & ~aw_full_q;
  assign wready  = init_q & ~w_full_q;
  assign arready = init_q & ~rvalid_q;

  assign aw_hs  = awvalid & awready;
  assign w_hs   = wvalid & wready;
  assign ar_hs  = arvalid & arready;
  assign commit = aw_full_q & w_full_q & ~bvalid_q;
  assign ar_idx = araddr[31:2];

  always_comb begin
    aw_full_d = aw_full_q;
    aw_idx_d  = aw_idx_q;
    w_full_d  = w_full_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    regs_d    = regs_q;

    if (aw_hs) begin
      aw_full_d = 1'b1;
      aw_idx_d  = awaddr[31:2];
    end
    if (w_hs) begin
      w_full_d = 1'b1;
      wdata_d  = wdata;
      wstrb_d  = wstrb;
    end

    if (bvalid_q && bready) begin
      bvalid_d = 1'b0;
    end

    // Commit only while no response is outstanding; an out-of-range index matches no register.
    if (commit) begin
      aw_full_d = 1'b0;
      w_full_d  = 1'b0;
      bvalid_d  = 1'b1;
      bresp_d   = (aw_idx_q < 30'(NUM_REGS)) ? RespOkay : RespDecerr;
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        if (aw_idx_q == 30'(i)) begin
          for (int k = 0; k < 4; k++) begin
            if (wstrb_q[k]) begin
              regs_d[i][8*k +: 8] = wdata_q[8*k +: 8];
            end
          end
        end
      end
    end

    if (rvalid_q && rready) begin
      rvalid_d = 1'b0;
    end

    // Reads sample regs_q, so a same-cycle commit is not visible to them.
    if (ar_hs) begin
      rvalid_d = 1'b1;
      rdata_d  = '0;
      rresp_d  = (ar_idx < 30'(NUM_REGS)) ? RespOkay : RespDecerr;
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        if (ar_idx == 30'(i)) begin
          rdata_d = regs_q[i];
        end
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      init_q    <= 1'b0;
      aw_full_q <= 1'b0;
      aw_idx_q  <= '0;
      w_full_q  <= 1'b0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RespOkay;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RespOkay;
      regs_q    <= '0;
    end else begin
      init_q    <= 1'b1;
      aw_full_q <= aw_full_d;
      aw_idx_q  <= aw_idx_d;
      w_full_q  <= w_full_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      regs_q    <= regs_d;
    end
  end

  assign bvalid = bvalid_q;
  assign bresp  = bresp_q;
  assign rvalid = rvalid_q;
  assign rdata  = rdata_q;
  assign rresp  = rresp_q;
  assign regs_o = regs_q;

endmodule

// File: tb/tb_axi_lite_reg_slave.sv
// Scoreboard bench for axi_lite_reg_slave: stimulus pushes expected B/R responses,
// a negedge monitor pops and compares them; the register model is a plain array.
module tb_axi_lite_reg_slave;

  localparam int unsigned NR = 16;

  logic              aclk = 1'b0;
  logic              aresetn;
  logic [31:0]       awaddr, wdata, araddr, rdata;
  logic [2:0]        awprot, arprot;
  logic [3:0]        wstrb;
  logic              awvalid, awready, wvalid, wready, bvalid, bready;
  logic              arvalid, arready, rvalid, rready;
  logic [1:0]        bresp, rresp;
  logic [32*NR-1:0]  regs_o;

  axi_lite_reg_slave #(.NUM_REGS(NR)) dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .awaddr  (awaddr),
    .awprot  (awprot),
    .awvalid (awvalid),
    .awready (awready),
    .wdata   (wdata),
    .wstrb   (wstrb),
    .wvalid  (wvalid),
    .wready  (wready),
    .bresp   (bresp),
    .bvalid  (bvalid),
    .bready  (bready),
    .araddr  (araddr),
    .arprot  (arprot),
    .arvalid (arvalid),
    .arready (arready),
    .rdata   (rdata),
    .rresp   (rresp),
    .rvalid  (rvalid),
    .rready  (rready),
    .regs_o  (regs_o)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
  } rexp_t;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] model [NR];
  logic [1:0]  b_q [$];
  rexp_t       r_q [$];
  logic        rand_rdy = 1'b0;
  logic        bready_dir = 1'b1;
  logic        rready_dir = 1'b1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [32*NR-1:0] model_flat();
    logic [32*NR-1:0] r;
    for (int i = 0; i < NR; i++) r[32*i +: 32] = model[i];
    return r;
  endfunction

  task automatic chk_regs(input string name);
    logic [32*NR-1:0] e;
    e = model_flat();
    n_checks++;
    if (regs_o !== e) begin
      n_fail++;
      $display("FAIL %s: regs_o got %0h expected %0h", name, regs_o, e);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out at %0t", name, $time);
  endtask

  // Ready driver: random backpressure or directed levels, updated just after each edge.
  initial begin
    bready = 1'b1;
    rready = 1'b1;
    forever begin
      @(posedge aclk);
      #2;
      if (rand_rdy) begin
        bready = 1'($urandom_range(0, 1));
        rready = 1'($urandom_range(0, 1));
      end else begin
        bready = bready_dir;
        rready = rready_dir;
      end
    end
  end

  // Monitor: pop one expectation per handshake seen on the B and R channels.
  always @(negedge aclk) begin : mon
    logic [1:0] be;
    rexp_t      re;
    if (aresetn) begin
      if (bvalid && bready) begin
        if (b_q.size() == 0) timeout_fail("unexpected_b");
        else begin
          be = b_q.pop_front();
          chk("bresp", 64'(bresp), 64'(be));
        end
      end
      if (rvalid && rready) begin
        if (r_q.size() == 0) timeout_fail("unexpected_r");
        else begin
          re = r_q.pop_front();
          chk("rdata", 64'(rdata), 64'(re.data));
          chk("rresp", 64'(rresp), 64'(re.resp));
        end
      end
    end
  end

  task automatic do_aw(input logic [31:0] addr);
    bit done = 0;
    awaddr  = addr;
    awvalid = 1'b1;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge aclk);
      if (awready) begin
        @(posedge aclk);
        #1;
        done = 1;
      end
    end
    awvalid = 1'b0;
    if (!done) timeout_fail("aw_handshake");
  endtask

  task automatic do_w(input logic [31:0] data, input logic [3:0] strb);
    bit done = 0;
    wdata  = data;
    wstrb  = strb;
    wvalid = 1'b1;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge aclk);
      if (wready) begin
        @(posedge aclk);
        #1;
        done = 1;
      end
    end
    wvalid = 1'b0;
    if (!done) timeout_fail("w_handshake");
  endtask

  task automatic do_ar(input logic [31:0] addr);
    bit done = 0;
    araddr  = addr;
    arvalid = 1'b1;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge aclk);
      if (arready) begin
        @(posedge aclk);
        #1;
        done = 1;
      end
    end
    arvalid = 1'b0;
    if (!done) timeout_fail("ar_handshake");
  endtask

  // Reference write: lanes with strobe set take the new byte, out-of-range is DECERR.
  task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                    input int dly_aw, input int dly_w);
    int unsigned idx;
    idx = int'(addr >> 2);
    if (idx < NR) begin
      for (int k = 0; k < 4; k++)
        if (strb[k]) model[idx][8*k +: 8] = data[8*k +: 8];
      b_q.push_back(2'b00);
    end else begin
      b_q.push_back(2'b11);
    end
    fork
      begin
        if (dly_aw > 0) begin repeat (dly_aw) @(posedge aclk); #1; end
        do_aw(addr);
      end
      begin
        if (dly_w > 0) begin repeat (dly_w) @(posedge aclk); #1; end
        do_w(data, strb);
      end
    join
  endtask

  function automatic rexp_t read_exp(input logic [31:0] addr);
    rexp_t e;
    int unsigned idx;
    idx = int'(addr >> 2);
    if (idx < NR) begin e.data = model[idx]; e.resp = 2'b00; end
    else begin e.data = 32'h0; e.resp = 2'b11; end
    return e;
  endfunction

  task automatic rd(input logic [31:0] addr);
    r_q.push_back(read_exp(addr));
    do_ar(addr);
  endtask

  task automatic drain();
    bit done = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      if (b_q.size() == 0 && r_q.size() == 0 && !bvalid && !rvalid) done = 1;
      else begin @(posedge aclk); #1; end
    end
    if (!done) timeout_fail("drain");
  endtask

  initial begin : stim
    logic [31:0] first_val, second_val, a, d;
    rexp_t       se;
    aresetn = 1'b0;
    awaddr = '0; wdata = '0; araddr = '0; wstrb = '0;
    awprot = '0; arprot = '0;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    for (int i = 0; i < NR; i++) model[i] = '0;

    // Reset state
    #12;
    chk("rst_awready", 64'(awready), 64'(0));
    chk("rst_wready", 64'(wready), 64'(0));
    chk("rst_arready", 64'(arready), 64'(0));
    chk("rst_bvalid", 64'(bvalid), 64'(0));
    chk("rst_rvalid", 64'(rvalid), 64'(0));
    chk("rst_bresp", 64'(bresp), 64'(0));
    chk("rst_rresp", 64'(rresp), 64'(0));
    chk("rst_rdata", 64'(rdata), 64'(0));
    chk_regs("rst_regs");
    @(negedge aclk);
    aresetn = 1'b1;
    #1;
    chk("awready_before_init", 64'(awready), 64'(0));
    @(posedge aclk);
    #1;
    chk("awready_after_init", 64'(awready), 64'(1));
    chk("wready_after_init", 64'(wready), 64'(1));
    chk("arready_after_init", 64'(arready), 64'(1));

    // Full write then read, with latency checks
    wr(32'h8, 32'hDEADBEEF, 4'hF, 0, 0);
    chk("bvalid_not_yet", 64'(bvalid), 64'(0));
    @(posedge aclk);
    #1;
    chk("bvalid_latency", 64'(bvalid), 64'(1));
    drain();
    rd(32'h8);
    chk("rvalid_latency", 64'(rvalid), 64'(1));
    drain();
    chk_regs("regs_after_deadbeef");

    // Partial strobes, AW/W together and W three cycles ahead of AW
    for (int pass = 0; pass < 2; pass++) begin
      wr(32'h4, 32'h11223344, 4'hF, 0, 0);
      drain();
      wr(32'h4, 32'hAABBCCDD, 4'h5, (pass == 1) ? 3 : 0, 0);
      drain();
      chk("strb_lane_merge", 64'(regs_o[63:32]), 64'(32'h11BB33DD));
      rd(32'h4);
      drain();
    end

    // Decode error
    wr(32'h40, 32'hCAFEF00D, 4'hF, 0, 0);
    drain();
    chk_regs("regs_after_decerr");
    rd(32'h40);
    drain();

    // Write backpressure: second pair accepted but held until first B handshake
    bready_dir = 1'b0;
    repeat (2) @(posedge aclk);
    #1;
    first_val  = 32'hA5A5_0001;
    second_val = 32'h5A5A_0002;
    wr(32'h0, first_val, 4'hF, 0, 0);
    wr(32'h0, second_val, 4'hF, 0, 0);
    for (int i = 0; i < 5; i++) begin
      chk("bp_reg0_holds_first", 64'(regs_o[31:0]), 64'(first_val));
      chk("bp_bvalid_held", 64'(bvalid), 64'(1));
      chk("bp_awready_low", 64'(awready), 64'(0));
      @(posedge aclk);
      #1;
    end
    bready_dir = 1'b1;
    drain();
    chk("bp_reg0_second", 64'(regs_o[31:0]), 64'(second_val));

    // Read backpressure
    rready_dir = 1'b0;
    repeat (2) @(posedge aclk);
    #1;
    rd(32'h8);
    for (int i = 0; i < 3; i++) begin
      chk("rbp_rvalid", 64'(rvalid), 64'(1));
      chk("rbp_rdata", 64'(rdata), 64'(32'hDEADBEEF));
      chk("rbp_arready", 64'(arready), 64'(0));
      @(posedge aclk);
      #1;
    end
    rready_dir = 1'b1;
    drain();

    // Read in the commit cycle sees the old value
    r_q.push_back(read_exp(32'hC));
    fork
      wr(32'hC, 32'h0000_1234, 4'hF, 0, 0);
      begin
        @(posedge aclk);
        #1;
        do_ar(32'hC);
      end
    join
    drain();
    chk("same_cycle_reg3", 64'(regs_o[127:96]), 64'(32'h1234));
    rd(32'hC);
    drain();

    // Randomised traffic with random B/R backpressure
    rand_rdy = 1'b1;
    for (int n = 0; n < 150; n++) begin
      a = 32'($urandom_range(0, NR + 3)) * 4 + 32'($urandom_range(0, 3));
      d = $urandom;
      if ($urandom_range(0, 2) != 0) begin
        wr(a, d, 4'($urandom_range(0, 15)), $urandom_range(0, 3), $urandom_range(0, 3));
        drain();
        chk_regs("rand_regs");
      end else begin
        rd(a);
        drain();
      end
    end
    rand_rdy = 1'b0;
    repeat (2) @(posedge aclk);
    #1;

    // Reset while a write response is pending
    bready_dir = 1'b0;
    repeat (2) @(posedge aclk);
    #1;
    wr(32'h10, 32'h0BAD_F00D, 4'hF, 0, 0);
    @(posedge aclk);
    #1;
    chk("pre_reset_bvalid", 64'(bvalid), 64'(1));
    #2;
    aresetn = 1'b0;
    #1;
    b_q.delete();
    r_q.delete();
    for (int i = 0; i < NR; i++) model[i] = '0;
    chk("mid_reset_bvalid", 64'(bvalid), 64'(0));
    chk("mid_reset_awready", 64'(awready), 64'(0));
    chk_regs("mid_reset_regs");
    bready_dir = 1'b1;
    @(negedge aclk);
    aresetn = 1'b1;
    @(posedge aclk);
    #1;
    chk("post_reset_awready", 64'(awready), 64'(1));
    rd(32'h8);
    drain();
    se = read_exp(32'h10);
    chk("post_reset_reg4", 64'(regs_o[159:128]), 64'(se.data));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
